// File: rtl/pcm_trigger_gen_pkg.sv
// Shared types and constants for the trigger generator feeding the q1/q2/q3 pulse sequencer.
package pcm_trigger_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int unsigned DEBOUNCE_DEFAULT = 4;
  localparam int unsigned HOLDOFF_DEFAULT  = 10;
  localparam int unsigned MAX_PEND_DEFAULT = 3;

  // Cycles from a sequencer `set` until q3 falls; HOLD must cover it.
  localparam int unsigned SEQ_LEN = 10;

endpackage

// File: rtl/pcm_trigger_gen_if.sv
// Request/trigger bundle between the trigger generator (slave) and its controller (master).
interface pcm_trigger_gen_if #(
  parameter int unsigned PW = 2
);
  logic          req_in;
  logic          en;
  logic          ovf_clr;
  logic          set;
  logic          busy;
  logic [PW-1:0] pend_cnt;
  logic          overflow;

  modport master (
    output req_in, en, ovf_clr,
    input  set, busy, pend_cnt, overflow
  );

  modport slave (
    input  req_in, en, ovf_clr,
    output set, busy, pend_cnt, overflow
  );
endinterface

// File: rtl/pcm_debounce.sv
// Two-flop synchroniser plus stable-count debounce; o_rise marks the edge where the level goes 0->1.
module pcm_debounce #(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  output logic o_level,
  output logic o_rise
);

  localparam int unsigned    CW       = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE - 1);

  logic          r_s1;
  logic          r_sync;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          w_mismatch;
  logic          w_done;

  assign w_mismatch = (r_sync != r_level);
  assign w_done     = w_mismatch && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1    <= 1'b0;
      r_sync  <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1   <= i_req;
      r_sync <= r_s1;
      if (!w_mismatch) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_cnt   <= '0;
        r_level <= r_sync;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Combinational so the pending counter increments on the same edge the level rises.
  assign o_level = r_level;
  assign o_rise  = w_done && r_sync;

endmodule

// File: rtl/pcm_trigger_gen.sv
// Queues debounced request edges and issues one 1-cycle `set` per request, spaced by a hold-off.
module pcm_trigger_gen
  import pcm_trigger_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEBOUNCE_DEFAULT,
  parameter int unsigned HOLDOFF  = HOLDOFF_DEFAULT,
  parameter int unsigned MAX_PEND = MAX_PEND_DEFAULT,
  parameter int unsigned PW       = 2
) (
  input logic              clk,
  input logic              rst_n,
  pcm_trigger_gen_if.slave trig
);

  localparam int unsigned   HW        = $clog2(HOLDOFF + 1);
  localparam logic [PW-1:0] MAX_P     = PW'(MAX_PEND);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF - 1);

  generate
    if (HOLDOFF + 1 < SEQ_LEN) begin : g_bad_holdoff
      $error("HOLDOFF+1 must be >= SEQ_LEN");
    end
    if ((2 ** PW) <= MAX_PEND) begin : g_bad_pw
      $error("PW too narrow for MAX_PEND");
    end
  endgenerate

  state_t        r_state;
  state_t        w_state_nxt;
  logic [HW-1:0] r_hold;
  logic [HW-1:0] w_hold_nxt;
  logic [PW-1:0] r_pend;
  logic [PW-1:0] w_pend_nxt;
  logic          r_ovf;
  logic          w_ovf_evt;
  logic          w_fire_dec;
  logic          w_pend_nz;
  logic          w_db_level;
  logic          w_req_evt;

  pcm_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req   (trig.req_in),
    .o_level (w_db_level),
    .o_rise  (w_req_evt)
  );

  assign w_pend_nz = (r_pend != '0);

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_fire_dec  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (trig.en && w_pend_nz) begin
          w_state_nxt = FIRE;
          w_fire_dec  = 1'b1;
        end
      end
      FIRE: begin
        w_state_nxt = HOLD;
        w_hold_nxt  = HOLD_LOAD;
      end
      HOLD: begin
        if (r_hold != '0) begin
          w_hold_nxt = r_hold - 1'b1;
        end else if (trig.en && w_pend_nz) begin
          w_state_nxt = FIRE;
          w_fire_dec  = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Simultaneous request and fire cancel out, so a full queue does not flag overflow then.
  always_comb begin
    w_pend_nxt = r_pend;
    w_ovf_evt  = 1'b0;
    if (w_req_evt && !w_fire_dec) begin
      if (r_pend == MAX_P) begin
        w_ovf_evt = 1'b1;
      end else begin
        w_pend_nxt = r_pend + 1'b1;
      end
    end else if (!w_req_evt && w_fire_dec) begin
      w_pend_nxt = r_pend - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_pend  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_pend  <= w_pend_nxt;
      if (w_ovf_evt) begin
        r_ovf <= 1'b1;
      end else if (trig.ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign trig.set      = (r_state == FIRE);
  assign trig.busy     = (r_state != IDLE);
  assign trig.pend_cnt = r_pend;
  assign trig.overflow = r_ovf;

endmodule

// File: tb/tb_pcm_trigger_gen.sv
// Directed bench: set pulses go through an expected-cycle scoreboard, levels are checked per edge.
module tb_pcm_trigger_gen;

  localparam int unsigned PW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pcm_trigger_gen_if #(.PW(PW)) trig ();

  pcm_trigger_gen #(
    .DEBOUNCE (4),
    .HOLDOFF  (10),
    .MAX_PEND (3),
    .PW       (PW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .trig  (trig)
  );

  int cyc   = 0;
  int n_chk = 0;
  int n_err = 0;
  int exp_q[$];
  int m_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: every observed set cycle must match the next expected pulse cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && trig.set === 1'b1) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL set_pulse: got pulse at cycle %0d expected none", cyc);
      end else begin
        m_exp = exp_q.pop_front();
        if (cyc != m_exp) begin
          n_err++;
          $display("FAIL set_pulse: got pulse at cycle %0d expected cycle %0d", cyc, m_exp);
        end
      end
    end
  end

  task automatic run(input int id, input int len);
    int e0 = cyc + 1;
    case (id)
      1: exp_q.push_back(e0 + 6);
      3: begin exp_q.push_back(e0 + 6);  exp_q.push_back(e0 + 17); exp_q.push_back(e0 + 28); end
      4: begin exp_q.push_back(e0 + 40); exp_q.push_back(e0 + 51); exp_q.push_back(e0 + 62); end
      5: begin exp_q.push_back(e0 + 13); exp_q.push_back(e0 + 24); end
      6: begin exp_q.push_back(e0 + 24); exp_q.push_back(e0 + 36); end
      default: ;
    endcase
    for (int k = 0; k <= len; k++) begin
      // drive for edge k
      case (id)
        1: trig.req_in = (k <= 20);
        2: trig.req_in = (k >= 2 && k <= 4);
        3: trig.req_in = (k < 24) && (k % 8 < 4);
        4: begin
          trig.req_in  = (k < 40) && (k % 8 < 4);
          trig.en      = (k >= 40);
          trig.ovf_clr = (k == 66);
        end
        5: begin
          trig.req_in = (k < 16) && (k % 8 < 4);
          trig.en     = (k >= 13);
        end
        6: begin
          trig.req_in = ((k < 24) && (k % 8 < 4)) || (k >= 30 && k < 34);
          trig.en     = (k >= 24);
          if (k == 27) rst_n = 1'b1;
        end
        default: ;
      endcase
      if (id == 6 && k == 25) begin
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_set",  trig.set, 0);
        check("t6_async_busy", trig.busy, 0);
        check("t6_async_pend", trig.pend_cnt, 0);
      end
      @(negedge clk);
      // checks after edge k
      case (id)
        1: case (k)
          4:  begin check("t1_pend_e4", trig.pend_cnt, 0); check("t1_db_e4", dut.w_db_level, 0); end
          5:  begin check("t1_pend_e5", trig.pend_cnt, 1); check("t1_db_e5", dut.w_db_level, 1);
                    check("t1_busy_e5", trig.busy, 0); end
          6:  begin check("t1_busy_e6", trig.busy, 1); check("t1_pend_e6", trig.pend_cnt, 0); end
          16: check("t1_busy_e16", trig.busy, 1);
          17: check("t1_busy_e17", trig.busy, 0);
          default: ;
        endcase
        2: case (k)
          7:  check("t2_db_e7", dut.w_db_level, 0);
          8:  check("t2_db_e8", dut.w_db_level, 0);
          15: begin check("t2_pend", trig.pend_cnt, 0); check("t2_busy", trig.busy, 0); end
          default: ;
        endcase
        3: case (k)
          5:  check("t3_pend_e5", trig.pend_cnt, 1);
          6:  check("t3_pend_e6", trig.pend_cnt, 0);
          13: check("t3_pend_e13", trig.pend_cnt, 1);
          16: begin check("t3_busy_e16", trig.busy, 1); check("t3_pend_e16", trig.pend_cnt, 1); end
          17: check("t3_pend_e17", trig.pend_cnt, 0);
          21: check("t3_pend_e21", trig.pend_cnt, 1);
          28: check("t3_pend_e28", trig.pend_cnt, 0);
          38: check("t3_busy_e38", trig.busy, 1);
          39: check("t3_busy_e39", trig.busy, 0);
          default: ;
        endcase
        4: case (k)
          5:  check("t4_pend_e5", trig.pend_cnt, 1);
          13: check("t4_pend_e13", trig.pend_cnt, 2);
          21: begin check("t4_pend_e21", trig.pend_cnt, 3); check("t4_ovf_e21", trig.overflow, 0); end
          28: check("t4_ovf_e28", trig.overflow, 0);
          29: begin check("t4_pend_e29", trig.pend_cnt, 3); check("t4_ovf_e29", trig.overflow, 1); end
          37: begin check("t4_pend_e37", trig.pend_cnt, 3); check("t4_ovf_e37", trig.overflow, 1);
                    check("t4_busy_e37", trig.busy, 0); end
          40: begin check("t4_pend_e40", trig.pend_cnt, 2); check("t4_busy_e40", trig.busy, 1); end
          51: check("t4_pend_e51", trig.pend_cnt, 1);
          62: check("t4_pend_e62", trig.pend_cnt, 0);
          65: check("t4_ovf_e65", trig.overflow, 1);
          66: check("t4_ovf_e66", trig.overflow, 0);
          73: check("t4_busy_e73", trig.busy, 0);
          default: ;
        endcase
        5: case (k)
          12: begin check("t5_pend_e12", trig.pend_cnt, 1); check("t5_busy_e12", trig.busy, 0); end
          13: begin check("t5_pend_e13", trig.pend_cnt, 1); check("t5_busy_e13", trig.busy, 1);
                    check("t5_ovf_e13", trig.overflow, 0); end
          24: check("t5_pend_e24", trig.pend_cnt, 0);
          35: check("t5_busy_e35", trig.busy, 0);
          default: ;
        endcase
        6: case (k)
          21: begin check("t6_pend_e21", trig.pend_cnt, 3); check("t6_busy_e21", trig.busy, 0); end
          24: begin check("t6_pend_e24", trig.pend_cnt, 2); check("t6_busy_e24", trig.busy, 1); end
          29: begin check("t6_pend_e29", trig.pend_cnt, 0); check("t6_busy_e29", trig.busy, 0); end
          34: check("t6_pend_e34", trig.pend_cnt, 0);
          35: check("t6_pend_e35", trig.pend_cnt, 1);
          36: begin check("t6_busy_e36", trig.busy, 1); check("t6_pend_e36", trig.pend_cnt, 0); end
          47: check("t6_busy_e47", trig.busy, 0);
          default: ;
        endcase
        default: ;
      endcase
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n        = 1'b0;
    trig.req_in  = 1'b0;
    trig.en      = 1'b1;
    trig.ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_set",  trig.set, 0);
    check("rst_busy", trig.busy, 0);
    check("rst_pend", trig.pend_cnt, 0);
    check("rst_ovf",  trig.overflow, 0);
    check("rst_db",   dut.w_db_level, 0);
    rst_n = 1'b1;

    run(1, 30);
    run(2, 15);
    run(3, 42);
    run(4, 76);
    run(5, 38);
    run(6, 50);

    while (exp_q.size() > 0) begin
      n_chk++;
      n_err++;
      $display("FAIL set_pulse: got no pulse expected one at cycle %0d", exp_q.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
